// File: rtl/cc_branch_sequencer_pkg.sv
// Shared control definitions for the SLC-3 condition-code / branch sequencer:
// FSM state encoding, opcode constants and PC mux selections.
package slc3_ctrl_pkg;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      DECODE   = 4'd1,
      BR_TEST  = 4'd2,
      BR_TAKE  = 4'd3,
      EXEC     = 4'd4,
      MEM_ADDR = 4'd5,
      MEM_RD   = 4'd6,
      WB       = 4'd7,
      DONE     = 4'd8
   } state_t;

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_NOT = 4'b1001;
   localparam logic [3:0] OP_LDR = 4'b0110;

   localparam logic [1:0] PCMUX_INC = 2'b00;
   localparam logic [1:0] PCMUX_BR  = 2'b10;

   // True for the single-cycle ALU ops that write a register and set CC.
   function automatic logic is_alu_op(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
   endfunction

endpackage

// File: rtl/cc_branch_sequencer_wait_counter.sv
// 4-bit loadable down-counter with a zero flag. Used to pace the memory
// read phase: loaded once, then decremented every cycle of the read,
// holding at zero rather than wrapping.
module wait_counter (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic       zero
);

   logic [3:0] count;

   // Load has priority over decrement; the count never wraps below zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= 4'd0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != 4'd0)) begin
         count <= count - 4'd1;
      end
   end

   assign zero = (count == 4'd0);

endmodule

// File: rtl/cc_branch_sequencer.sv
// Moore sequencer for one SLC-3 instruction per Start handshake: latches the
// instruction, steps the CC/BEN unit and datapath strobes for BR, ADD, AND,
// NOT and LDR, and flags unsupported opcodes.
// Optional build macro BR_COUNT_EN adds saturating branch statistics
// counters; without it Br_Taken_Cnt and Br_Total_Cnt read as zero.
module cc_branch_sequencer
   import slc3_ctrl_pkg::*;
#(
   parameter int MEM_WAIT = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic [15:0] Instr_In,
   input  logic        BEN_Out,
   output logic [15:0] IR,
   output logic        LD_CC,
   output logic        LD_BEN,
   output logic        LD_REG,
   output logic        LD_PC,
   output logic        LD_MAR,
   output logic        LD_MDR,
   output logic        GateALU,
   output logic        GateMDR,
   output logic        GateMARMUX,
   output logic        Mem_OE,
   output logic [1:0]  PCMUX,
   output logic        Busy,
   output logic        Done,
   output logic        Illegal,
   output logic [15:0] Br_Taken_Cnt,
   output logic [15:0] Br_Total_Cnt
);

   localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

   state_t     state;
   state_t     state_next;
   logic       illegal_q;
   logic       wait_zero;
   logic [3:0] opcode;

   assign opcode = IR[15:12];

   // State register; reset overrides any in-flight instruction.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Instruction latch: captured only when a Start is accepted in IDLE.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         IR <= 16'h0000;
      end else if ((state == IDLE) && Start) begin
         IR <= Instr_In;
      end
   end

   // Illegal flag: decided in DECODE, shown with Done, cleared on leaving DONE.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         illegal_q <= 1'b0;
      end else if (state == DECODE) begin
         illegal_q <= !((opcode == OP_BR) || (opcode == OP_LDR) || is_alu_op(opcode));
      end else if (state == DONE) begin
         illegal_q <= 1'b0;
      end
   end

   wait_counter u_wait (
      .clk      (Clk),
      .reset    (Reset),
      .load     (state == MEM_ADDR),
      .load_val (WAIT_LOAD),
      .dec      (state == MEM_RD),
      .zero     (wait_zero)
   );

   // Next-state decode; unknown encodings fall back to IDLE.
   always_comb begin
      state_next = IDLE;
      case (state)
         IDLE:     state_next = Start ? DECODE : IDLE;
         DECODE: begin
            if (opcode == OP_BR) begin
               state_next = BR_TEST;
            end else if (is_alu_op(opcode)) begin
               state_next = EXEC;
            end else if (opcode == OP_LDR) begin
               state_next = MEM_ADDR;
            end else begin
               state_next = DONE;
            end
         end
         BR_TEST:  state_next = BEN_Out ? BR_TAKE : DONE;
         BR_TAKE:  state_next = DONE;
         EXEC:     state_next = DONE;
         MEM_ADDR: state_next = MEM_RD;
         MEM_RD:   state_next = wait_zero ? WB : MEM_RD;
         WB:       state_next = DONE;
         DONE:     state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // Strobe decode from registered state only.
   always_comb begin
      LD_CC      = 1'b0;
      LD_BEN     = 1'b0;
      LD_REG     = 1'b0;
      LD_PC      = 1'b0;
      LD_MAR     = 1'b0;
      LD_MDR     = 1'b0;
      GateALU    = 1'b0;
      GateMDR    = 1'b0;
      GateMARMUX = 1'b0;
      Mem_OE     = 1'b0;
      PCMUX      = PCMUX_INC;
      Busy       = (state != IDLE);
      Done       = 1'b0;
      Illegal    = 1'b0;
      case (state)
         DECODE:   LD_BEN = 1'b1;
         BR_TAKE: begin
            LD_PC = 1'b1;
            PCMUX = PCMUX_BR;
         end
         EXEC: begin
            GateALU = 1'b1;
            LD_REG  = 1'b1;
            LD_CC   = 1'b1;
         end
         MEM_ADDR: begin
            GateMARMUX = 1'b1;
            LD_MAR     = 1'b1;
         end
         MEM_RD: begin
            Mem_OE = 1'b1;
            LD_MDR = wait_zero;
         end
         WB: begin
            GateMDR = 1'b1;
            LD_REG  = 1'b1;
            LD_CC   = 1'b1;
         end
         DONE: begin
            Done    = 1'b1;
            Illegal = illegal_q;
         end
         default: ;
      endcase
   end

`ifdef BR_COUNT_EN
   logic [15:0] taken_cnt;
   logic [15:0] total_cnt;

   // Branch statistics; both counters stick at all-ones.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         taken_cnt <= 16'h0000;
         total_cnt <= 16'h0000;
      end else begin
         if ((state == BR_TEST) && (total_cnt != 16'hFFFF)) begin
            total_cnt <= total_cnt + 16'd1;
         end
         if ((state == BR_TAKE) && (taken_cnt != 16'hFFFF)) begin
            taken_cnt <= taken_cnt + 16'd1;
         end
      end
   end

   assign Br_Taken_Cnt = taken_cnt;
   assign Br_Total_Cnt = total_cnt;
`else
   assign Br_Taken_Cnt = 16'h0000;
   assign Br_Total_Cnt = 16'h0000;
`endif

endmodule
